// File: rtl/riscv_core_mul_seq_if.sv
// Request/response bundle for the iterative RV64M multiply unit.
// The unit is the slave side; the issuing execute stage is the master.
interface riscv_core_mul_seq_if #(
    parameter int XLEN = 64
);
    logic            i_mul_valid;
    logic            o_mul_ready;
    logic [XLEN-1:0] i_mul_srcA;
    logic [XLEN-1:0] i_mul_srcB;
    logic [1:0]      i_mul_control;
    logic            i_mul_isword;
    logic            i_mul_flush;
    logic            o_mul_valid;
    logic            i_mul_ready;
    logic [XLEN-1:0] o_mul_result;
    logic            o_mul_busy;

    modport master (
        output i_mul_valid, i_mul_srcA, i_mul_srcB, i_mul_control, i_mul_isword,
               i_mul_flush, i_mul_ready,
        input  o_mul_ready, o_mul_valid, o_mul_result, o_mul_busy
    );

    modport slave (
        input  i_mul_valid, i_mul_srcA, i_mul_srcB, i_mul_control, i_mul_isword,
               i_mul_flush, i_mul_ready,
        output o_mul_ready, o_mul_valid, o_mul_result, o_mul_busy
    );
endinterface

// File: rtl/riscv_core_mul_seq.sv
// Iterative RV64M multiplier (MUL/MULH/MULHSU/MULHU/MULW), radix-2^BITS_PER_CYCLE shift-add.
// Optional MUL_EARLY_OUT_EN: leave BUSY as soon as the remaining multiplier bits are zero.
module riscv_core_mul_seq #(
    parameter int XLEN           = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    riscv_core_mul_seq_if.slave  mul
);
    localparam int HALF   = XLEN / 2;
    localparam int ITER_D = XLEN / BITS_PER_CYCLE;
    localparam int ITER_W = HALF / BITS_PER_CYCLE;
    localparam int CW     = $clog2(ITER_D);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;
    typedef enum logic [1:0] {OP_MUL = 2'b00, OP_MULH = 2'b01,
                              OP_MULHSU = 2'b10, OP_MULHU = 2'b11} mul_op_t;

    state_t            state, state_nxt;
    logic [2*XLEN-1:0] acc, mcand, partial, acc_fix;
    logic [XLEN-1:0]   mplier, result;
    logic [CW-1:0]     cnt, last_cnt;
    logic              neg_res, is_word, want_hi;
    logic              accept, busy_last;
    logic              s_a, s_b;
    logic [HALF-1:0]   lo_a, lo_b;
    logic [XLEN-1:0]   mag_a, mag_b;

    // Flush in IDLE wins over a request, so nothing is taken that cycle.
    assign accept = (state == S_IDLE) && mul.i_mul_valid && !mul.i_mul_flush;
    assign lo_a   = mul.i_mul_srcA[HALF-1:0];
    assign lo_b   = mul.i_mul_srcB[HALF-1:0];

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        s_a   = 1'b0;
        s_b   = 1'b0;
        mag_a = mul.i_mul_srcA;
        mag_b = mul.i_mul_srcB;
        if (mul.i_mul_isword) begin
            s_a   = lo_a[HALF-1];
            s_b   = lo_b[HALF-1];
            mag_a = {{HALF{1'b0}}, (s_a ? -lo_a : lo_a)};
            mag_b = {{HALF{1'b0}}, (s_b ? -lo_b : lo_b)};
        end else begin
            case (mul_op_t'(mul.i_mul_control))
                OP_MUL, OP_MULH: begin
                    s_a = mul.i_mul_srcA[XLEN-1];
                    s_b = mul.i_mul_srcB[XLEN-1];
                end
                OP_MULHSU: s_a = mul.i_mul_srcA[XLEN-1];
                default: ;
            endcase
            mag_a = s_a ? -mul.i_mul_srcA : mul.i_mul_srcA;
            mag_b = s_b ? -mul.i_mul_srcB : mul.i_mul_srcB;
        end
    end

    // One radix digit of the multiplier times the shifted multiplicand.
    always_comb begin
        partial = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (mplier[j]) partial = partial + (mcand << j);
        end
    end

    assign last_cnt = is_word ? CW'(ITER_W - 1) : CW'(ITER_D - 1);
`ifdef MUL_EARLY_OUT_EN
    assign busy_last = (cnt == last_cnt) || (mplier == '0);
`else
    assign busy_last = (cnt == last_cnt);
`endif

    assign acc_fix = neg_res ? -acc : acc;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_BUSY;
            S_BUSY: begin
                if (mul.i_mul_flush)  state_nxt = S_IDLE;
                else if (busy_last)   state_nxt = S_FIX;
            end
            S_FIX:  state_nxt = mul.i_mul_flush ? S_IDLE : S_DONE;
            S_DONE: if (mul.i_mul_flush || mul.i_mul_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            neg_res <= 1'b0;
            is_word <= 1'b0;
            want_hi <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    acc     <= '0;
                    mcand   <= {{XLEN{1'b0}}, mag_a};
                    mplier  <= mag_b;
                    cnt     <= '0;
                    neg_res <= s_a ^ s_b;
                    is_word <= mul.i_mul_isword;
                    want_hi <= (mul.i_mul_control != OP_MUL);
                end
                S_BUSY: begin
                    acc    <= acc + partial;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    cnt    <= cnt + 1'b1;
                end
                S_FIX: if (!mul.i_mul_flush) begin
                    if (is_word)      result <= {{HALF{acc_fix[HALF-1]}}, acc_fix[HALF-1:0]};
                    else if (want_hi) result <= acc_fix[2*XLEN-1:XLEN];
                    else              result <= acc_fix[XLEN-1:0];
                end
                default: ;
            endcase
        end
    end

    assign mul.o_mul_ready  = (state == S_IDLE);
    assign mul.o_mul_valid  = (state == S_DONE);
    assign mul.o_mul_busy   = (state != S_IDLE);
    assign mul.o_mul_result = result;
endmodule
